// File: rtl/clock_divider_if.sv
// Output bundle of the clock divider: the divided clock and its two
// clk_in-domain edge strobes. The divider drives it (master) and
// downstream clocking logic observes it (slave).
interface clock_divider_if;
    logic clk_out;
    logic rise_tick;
    logic fall_tick;

    modport master (
        output clk_out,
        output rise_tick,
        output fall_tick
    );

    modport slave (
        input clk_out,
        input rise_tick,
        input fall_tick
    );
endinterface

// File: rtl/clock_divider.sv
// Divide-by-DIV clock generator with 50 % duty cycle for both even and odd
// ratios, plus single-cycle rise/fall strobes in the clk_in domain.
//
// A phase counter walks 0..DIV-1 on rising clk_in edges. A rising-edge
// flop (high_reg) holds the integer part of the high phase. For odd ratios
// a falling-edge flop (b_reg) re-times high_reg by half a cycle, and the
// OR of the two stretches the high phase by exactly half a clk_in period.
// clk_out is therefore always a function of flop outputs only, so it
// cannot glitch on counter transitions.
module clock_divider #(
    parameter int DIV   = 2,
    parameter int CNT_W = (DIV > 2) ? $clog2(DIV) : 1
) (
    input  logic            clk_in,
    input  logic            rst,
    clock_divider_if.master div_if
);

    // A ratio below 2 has no meaningful divided clock; stop elaboration.
    generate
        if (DIV < 2) begin : g_bad_div
            $error("clock_divider: DIV must be >= 2");
        end
    endgenerate

    // Last counter value; the counter restarts from here after reset so
    // that the first rising edge lands on phase 0.
    localparam logic [CNT_W-1:0] LAST_P = CNT_W'(DIV - 1);

    // Phase whose cycle carries the falling edge of clk_out.
    localparam logic [CNT_W-1:0] FALL_P = CNT_W'(DIV / 2);

    // Whole clk_in cycles that high_reg stays set. For odd DIV the extra
    // half cycle comes from b_reg.
    localparam int HIGH_CYC = (DIV % 2 == 0) ? (DIV / 2) : ((DIV - 1) / 2);
    localparam logic [CNT_W-1:0] HIGH_LIM = CNT_W'(HIGH_CYC);

    logic [CNT_W-1:0] p_reg;
    logic [CNT_W-1:0] p_next;
    logic             high_reg;
    logic             rise_reg;
    logic             fall_reg;

    // Next phase: wrap from DIV-1 back to 0.
    always_comb begin
        p_next = p_reg + CNT_W'(1);
        if (p_reg == LAST_P) begin
            p_next = '0;
        end
    end

    // Phase counter, integer high phase and edge strobes, all registered
    // from the next phase so they line up with the counter value.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            p_reg    <= LAST_P;
            high_reg <= 1'b0;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            p_reg    <= p_next;
            high_reg <= (p_next < HIGH_LIM);
            rise_reg <= (p_next == '0);
            fall_reg <= (p_next == FALL_P);
        end
    end

    generate
        if (DIV % 2 == 1) begin : g_odd
            logic b_reg;

            // Half-cycle delayed copy of the high phase; it keeps clk_out
            // high through the first half of the cycle after high_reg drops.
            always_ff @(negedge clk_in or posedge rst) begin
                if (rst) begin
                    b_reg <= 1'b0;
                end else begin
                    b_reg <= high_reg;
                end
            end

            // b_reg is stable whenever high_reg changes and vice versa, so
            // the OR cannot produce a runt pulse.
            assign div_if.clk_out = high_reg | b_reg;
        end else begin : g_even
            assign div_if.clk_out = high_reg;
        end
    endgenerate

    assign div_if.rise_tick = rise_reg;
    assign div_if.fall_tick = fall_reg;

endmodule

// File: tb/tb_clock_divider.sv
// Bench for clock_divider: four instances (DIV = 2, 3, 4, 5) share one
// clk_in and one rst. The stimulus process pushes expected outputs into a
// queue at each sample point; a monitor process pops and compares them.
// Expected values come from the time-domain definition of a 50 % clock:
// clk_out is high when (time since release) mod period < period / 2.
module tb_clock_divider;

    logic clk_in;
    logic rst;

    clock_divider_if if2();
    clock_divider_if if3();
    clock_divider_if if4();
    clock_divider_if if5();

    clock_divider #(.DIV(2)) u_div2 (.clk_in(clk_in), .rst(rst), .div_if(if2));
    clock_divider #(.DIV(3)) u_div3 (.clk_in(clk_in), .rst(rst), .div_if(if3));
    clock_divider #(.DIV(4)) u_div4 (.clk_in(clk_in), .rst(rst), .div_if(if4));
    clock_divider #(.DIV(5)) u_div5 (.clk_in(clk_in), .rst(rst), .div_if(if5));

    // clk_in period is 10 time units: rising edges at 5, 15, 25, ...
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic [3:0] act_co;
    logic [3:0] act_rt;
    logic [3:0] act_ft;
    assign act_co = {if5.clk_out,   if4.clk_out,   if3.clk_out,   if2.clk_out};
    assign act_rt = {if5.rise_tick, if4.rise_tick, if3.rise_tick, if2.rise_tick};
    assign act_ft = {if5.fall_tick, if4.fall_tick, if3.fall_tick, if2.fall_tick};

    typedef struct {
        int   idx;
        logic co;
        logic rt;
        logic ft;
    } exp_t;

    exp_t exp_q[$];
    event sample_ev;

    int checks   = 0;
    int failures = 0;

    bit meas_en  = 1'b0;
    bit count_en = 1'b0;
    int rise_cnt5;

    int     n_hi3, n_per3, n_hi5, n_per5;
    longint hi_sum3, lo_sum3, hi_sum5, lo_sum5;

    task automatic chk_bit(input string name, input int div, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s div=%0d t=%0t got=%b want=%b", name, div, $time, got, want);
        end
    endtask

    task automatic chk_int(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, got, want);
        end
    endtask

    // Expected outputs for all four dividers, k clk_in cycles after
    // release, in the first or second half of that cycle.
    task automatic push_run(input int k, input bit second_half);
        exp_t e;
        int   d;
        int   m;
        int   q;
        for (int i = 0; i < 4; i++) begin
            d     = i + 2;
            m     = k % d;
            q     = 4 * m + (second_half ? 3 : 1);   // time in quarter cycles
            e.idx = i;
            e.co  = (q < 2 * d);
            e.rt  = (m == 0);
            e.ft  = (m == d / 2);
            exp_q.push_back(e);
        end
        -> sample_ev;
    endtask

    task automatic push_reset();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.idx = i;
            e.co  = 1'b0;
            e.rt  = 1'b0;
            e.ft  = 1'b0;
            exp_q.push_back(e);
        end
        -> sample_ev;
    endtask

    // Monitor: compare the DUT outputs against each queued expectation.
    exp_t mon_e;
    initial begin
        forever begin
            @(sample_ev);
            while (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk_bit("clk_out",   mon_e.idx + 2, act_co[mon_e.idx], mon_e.co);
                chk_bit("rise_tick", mon_e.idx + 2, act_rt[mon_e.idx], mon_e.rt);
                chk_bit("fall_tick", mon_e.idx + 2, act_ft[mon_e.idx], mon_e.ft);
            end
        end
    end

    // Hold reset for n cycles checking both halves, then release just
    // after a falling edge so the next rising edge is cycle 0.
    task automatic hold_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            #2 push_reset();
            @(negedge clk_in);
            #2 push_reset();
        end
        rst = 1'b0;
    endtask

    task automatic run(input int len);
        for (int k = 0; k < len; k++) begin
            @(posedge clk_in);
            #2 push_run(k, 1'b0);
            if (count_en && act_rt[3] === 1'b1) rise_cnt5++;
            @(negedge clk_in);
            #2 push_run(k, 1'b1);
        end
    endtask

    // Check cycle k at offset off, then assert reset asynchronously and
    // check that everything is 0 before the next clk_in edge.
    task automatic mid_reset(input int k, input int off);
        @(posedge clk_in);
        #(off) push_run(k, off > 5);
        #1 rst = 1'b1;
        #1 push_reset();
    endtask

    // Edge-time measurement of one odd divider's clk_out while meas_en.
    task automatic measure(input int d, output int n_hi, output int n_per,
                           output longint hi_sum, output longint lo_sum);
        longint t_r, t_f, w, pend;
        bit     r_ok, f_ok, pend_ok;
        logic   co;
        r_ok = 0; f_ok = 0; pend_ok = 0;
        t_r = 0; t_f = 0; pend = 0;
        n_hi = 0; n_per = 0; hi_sum = 0; lo_sum = 0;
        while (meas_en) begin
            if (d == 3) @(if3.clk_out or meas_en);
            else        @(if5.clk_out or meas_en);
            if (!meas_en) break;
            co = (d == 3) ? if3.clk_out : if5.clk_out;
            if (co === 1'b1) begin
                chk_bit("rise_on_clk_in_high", d, clk_in, 1'b1);
                if (f_ok) begin
                    w = longint'($time) - t_f;
                    chk_int("low_time", w, longint'(5 * d));
                    if (pend_ok) begin
                        lo_sum += w;
                        hi_sum += pend;
                        n_per++;
                    end
                end
                t_r  = longint'($time);
                r_ok = 1;
            end else begin
                chk_bit("fall_on_clk_in_low", d, clk_in, 1'b0);
                if (r_ok) begin
                    w = longint'($time) - t_r;
                    chk_int("high_time", w, longint'(5 * d));
                    pend    = w;
                    pend_ok = 1;
                    n_hi++;
                end
                t_f  = longint'($time);
                f_ok = 1;
            end
        end
    endtask

    initial begin
        int len;
        int off;
        rst = 1'b1;

        // Reset held 5 cycles, then 16 cycles; reset lands while the
        // divide-by-2 output is high (cycle 16 is phase 0 for DIV=2).
        hold_reset(5);
        run(16);
        mid_reset(16, 2);

        // Random reset lengths, run lengths and reset instants.
        for (int ep = 0; ep < 6; ep++) begin
            hold_reset($urandom_range(1, 4));
            len = $urandom_range(8, 40);
            run(len);
            case ($urandom_range(0, 3))
                0: off = 1;
                1: off = 2;
                2: off = 6;
                default: off = 7;
            endcase
            mid_reset(len, off);
        end

        // Long run: duty-cycle measurement on the odd dividers and the
        // rise_tick count over 100 DIV=5 output periods.
        hold_reset(3);
        rise_cnt5 = 0;
        count_en  = 1'b1;
        meas_en   = 1'b1;
        fork
            begin
                run(500);
                meas_en  = 1'b0;
                count_en = 1'b0;
            end
            measure(3, n_hi3, n_per3, hi_sum3, lo_sum3);
            measure(5, n_hi5, n_per5, hi_sum5, lo_sum5);
        join
        chk_int("rise_tick_count_div5", rise_cnt5, 100);
        chk_int("high_phases_div5", n_hi5, 100);
        chk_int("full_periods_div5", n_per5, 99);
        chk_int("high_vs_low_sum_div5", hi_sum5, lo_sum5);
        chk_int("high_phases_div3", n_hi3, 167);
        chk_int("high_vs_low_sum_div3", hi_sum3, lo_sum3);
        mid_reset(500, 6);

        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog t=%0t got=running want=finished", $time);
        $fatal(1, "time limit reached");
    end

endmodule
